// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: serial-frame receiver with an output word queue.
// Deserialises one bit per clock. Frames are a start bit (0), DATA_W data
// bits LSB first, an optional odd-parity bit and a stop bit (1). Good words
// are pushed into a FIFO_DEPTH-deep queue that is drained over valid/ready.
// Build option: define PARITY_RX_EN to add the parity bit and its check.
module serial_rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          done,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
`ifdef PARITY_RX_EN
    PARITY,
`endif
    STOP,
    RESYNC
  } state_t;

  state_t              state;
  logic [BW-1:0]       bit_cnt;
  logic [DATA_W-1:0]   shift_reg;
  logic                parity_ok;

  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;

  logic                stop_ok;
  logic                word_good;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;

`ifdef PARITY_RX_EN
  logic                par_bit;
  // Odd parity: data bits plus parity bit must XOR to 1.
  assign parity_ok = ^{shift_reg, par_bit};
`else
  assign parity_ok = 1'b1;
  assign parity_err = 1'b0;
`endif

  // A full FIFO still accepts a push when the head is popped on the same edge.
  assign stop_ok   = (state == STOP) && in;
  assign word_good = stop_ok && parity_ok;
  assign full      = (count == FULL_CNT);
  assign pop       = out_valid && out_ready;
  assign push      = word_good && (!full || pop);
  assign drop      = word_good && full && !pop;

  assign out_valid  = (count != '0);
  assign fifo_count = count;
  // Gated so out_data reads 0 while empty, including straight after reset.
  assign out_data   = out_valid ? mem[rd_ptr] : '0;

  // Frame FSM with registered status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      done      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef PARITY_RX_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      done      <= push;
      overrun   <= drop;
      frame_err <= (state == STOP) && !in;
`ifdef PARITY_RX_EN
      parity_err <= stop_ok && !parity_ok;
`endif
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (!in) state <= DATA;
        end
        DATA: begin
          shift_reg <= {in, shift_reg[DATA_W-1:1]};
          bit_cnt   <= bit_cnt + BW'(1);
          if (bit_cnt == LAST_BIT) begin
`ifdef PARITY_RX_EN
            state <= PARITY;
`else
            state <= STOP;
`endif
          end
        end
`ifdef PARITY_RX_EN
        PARITY: begin
          par_bit <= in;
          state   <= STOP;
        end
`endif
        STOP: begin
          state <= in ? IDLE : RESYNC;
        end
        RESYNC: begin
          if (in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Word storage; contents need no reset because out_data is gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

endmodule

// File: doc/serial_rx_fifo.md
# serial_rx_fifo

Parametrised serial-frame receiver with output buffering, successor to the single-byte `serial_if` receiver (`in`, `out_byte`, `done`). It deserialises one bit per clock into words of DATA_W bits and optionally checks odd parity. Good words are queued in a small FIFO drained over a valid/ready handshake. It reports framing, parity and overrun errors, and sits between the serial line pin logic and the downstream word consumer.

## Interface
Parameters:
- DATA_W, 8, data bits per frame; legal 5..16.
- FIFO_DEPTH, 4, output queue depth in words; power of two, ≥2.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in  in  1  serial line, sampled once per clk; idle = 1.
- out_data  out  DATA_W  head-of-FIFO word, LSB = first data bit received.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head word when out_valid & out_ready.
- done  out  1  one-cycle pulse when a good word is pushed to the FIFO.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled as 0.
- parity_err  out  1  one-cycle pulse when a frame fails odd parity.
- overrun  out  1  one-cycle pulse when a good word is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words currently held.

## Operation
- Frame format: start bit (0), DATA_W data bits LSB first, parity bit (only with PARITY_EN), stop bit (1).
- FSM states:
  - IDLE: in==0 → DATA with bit_cnt=0; otherwise stay.
  - DATA: shift in one bit per cycle; after DATA_W bits go to PARITY (PARITY_EN) or STOP.
  - PARITY: capture one bit → STOP.
  - STOP:
    - in==1: frame accepted → IDLE. In the next cycle, in==0 is a new start bit, so back-to-back frames need no idle gap.
    - in==0: frame_err pulses and the word is discarded → RESYNC.
  - RESYNC: wait for in==1 → IDLE. The cycle with in==1 is not a start bit.
- Accepted frame:
  - Parity fails (PARITY_EN): parity_err pulses; no push; done stays 0.
  - FIFO has space: push the word; done pulses.
  - FIFO full: overrun pulses; word dropped; FIFO contents unchanged.
- Simultaneous push and pop with the FIFO full: the push is accepted and fifo_count is unchanged.
- Push and pop in the same cycle otherwise: fifo_count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
- out_data is stable while out_valid & !out_ready.
- Reset, including mid-frame or mid-drain:
  - FSM → IDLE; partial frame discarded; FIFO emptied.
  - All outputs 0: out_data=0, out_valid=0, done=0, frame_err=0, parity_err=0, overrun=0, fifo_count=0.
  - First cycle after release with in==0 is treated as a start bit.

## Timing
- Bit k of a frame is sampled at edge k, counting the start-bit edge as 0.
- Stop bit is sampled at edge S = DATA_W+1, or DATA_W+2 with PARITY_EN.
- At edge S, the following register together:
  - done, frame_err, parity_err and overrun each assert for exactly the cycle after edge S.
  - On a push, out_valid rises after edge S when the FIFO was empty; first-word latency is 0 cycles after the stop edge.
- A pop occurs at an edge where out_valid & out_ready. The next word, or out_valid=0, is visible after that edge.
- Throughput: one word per DATA_W+2 (or +3) cycles sustained. The FIFO absorbs FIFO_DEPTH words of consumer stall.

## Configuration
- PARITY_RX_EN defined:
  - PARITY state present.
  - Check: XOR of the DATA_W data bits and the parity bit must equal 1 (odd parity).
  - Frame length is DATA_W+3 bits.
- PARITY_RX_EN undefined:
  - No PARITY state; frame length is DATA_W+2 bits.
  - parity_err tied to 0.

## Test plan
- DATA_W=8, no parity, line bits 0,1,0,1,0,0,1,0,1,1 (0xA5) → done pulses after the stop edge; out_valid=1; out_data=8'hA5; fifo_count=1.
- PARITY_RX_EN, 0xA5 sent with parity bit 1 → word pushed. Same frame with parity bit 0 → parity_err pulse, no push, fifo_count unchanged.
- Stop bit 0 after 0x3C, line held low 3 cycles then high, then a frame 0x81 → frame_err pulse; 0x3C discarded; no start detected in RESYNC; 0x81 received correctly.
- out_ready=0, FIFO_DEPTH=4, five back-to-back frames 0x01..0x05 → fifo_count=4; overrun pulses on 0x05; draining yields 0x01,0x02,0x03,0x04.
- FIFO full, out_ready=1 exactly at the stop edge of a 5th frame → pop and push in the same cycle; no overrun; fifo_count stays 4; order preserved.
- rst asserted mid-frame (after 4 data bits) with 2 words queued → all outputs 0, fifo_count=0 immediately. A following full frame 0x5A is received cleanly.
